// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared pipeline definitions for the 5-stage RISC core.
// Holds the default register address width, the stage index of each
// scoreboard slot, the default-width scoreboard entry and the issue FSM states.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;

  // Scoreboard slot index for each downstream stage.
  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
  } sb_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;
endpackage

// File: rtl/pipeline_hazard_controller_scoreboard.sv
// hazard_scoreboard: shift register of destination registers in flight in
// EX/MEM/WB plus the source-operand match comparators.
// Ports: clock/reset (sync, active high); issue/reg_we/rd record the issuing
// instruction; id_valid/rs1/rs2/uses_rs1/uses_rs2 describe the ID reader;
// hazard is the combinational read-after-write hazard flag.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int DEPTH      = 3,
  parameter bit R0_IS_ZERO = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue,
  input  logic                  reg_we,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs1,
  input  logic                  uses_rs2,
  output logic                  hazard
);
  import cpu_pkg::*;

  // Entry sized by this instance's address width.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
  } entry_t;

  entry_t [DEPTH-1:0] slot;
  logic               record;
  logic               m1, m2;

  // Writes to r0 are discarded by the register file, so they never block.
  assign record = issue & reg_we & ~(R0_IS_ZERO & (rd == '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      slot <= '0;
    end else begin
      slot[EX] <= record ? entry_t'{valid: 1'b1, rd: rd} : '0;
      for (int i = 1; i < DEPTH; i++) slot[i] <= slot[i-1];
    end
  end

  always_comb begin
    m1 = 1'b0;
    m2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot[i].valid && slot[i].rd == rs1) m1 = 1'b1;
      if (slot[i].valid && slot[i].rd == rs2) m2 = 1'b1;
    end
  end

  assign hazard = id_valid & ((uses_rs1 & m1) | (uses_rs2 & m2));
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: issue/hazard sequencer for the 5-stage pipeline.
// Stalls PC/IR on RAW hazards, bubbles the EX stage register, squashes the
// wrong-path fetch after a taken branch/jump and counts stall/flush cycles.
// Ports: clock, reset (sync, active high); id_* describe the instruction in IR;
// stall/bubble/flush/issue steer PC, IR and the EX write-enables;
// stall_count/flush_count are saturating event counters.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W   = cpu_pkg::REG_ADDR_W,
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter bit R0_IS_ZERO   = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_we,
  input  logic                  id_branch_taken,
  output logic                  stall,
  output logic                  bubble,
  output logic                  flush,
  output logic                  issue,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);
  import cpu_pkg::*;

  state_t     state, state_n;
  logic [1:0] fcnt, fcnt_n;
  logic       hazard;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .DEPTH      (DEPTH),
    .R0_IS_ZERO (R0_IS_ZERO)
  ) u_sb (
    .clock    (clock),
    .reset    (reset),
    .issue    (issue),
    .reg_we   (id_reg_we),
    .rd       (id_rd),
    .id_valid (id_valid),
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .uses_rs1 (id_uses_rs1),
    .uses_rs2 (id_uses_rs2),
    .hazard   (hazard)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
    end
  end

  // A branch held in a hazard stall only takes effect on the cycle it issues.
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    case (state)
      RUN: begin
        if (id_valid && !hazard && id_branch_taken) begin
          state_n = FLUSH;
          fcnt_n  = 2'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (fcnt <= 2'd1) state_n = RUN;
        else              fcnt_n  = fcnt - 2'd1;
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    stall  = 1'b0;
    flush  = 1'b0;
    issue  = 1'b0;
    bubble = 1'b1;
    if (!reset) begin
      case (state)
        RUN: begin
          stall  = hazard;
          bubble = hazard | ~id_valid;
          issue  = id_valid & ~hazard;
        end
        FLUSH:   flush = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (flush && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
endmodule
